// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one core request at a time, commits writes
// at acceptance, and returns a response after a fixed programmable latency.

package dmem_responder_pkg;
   typedef struct packed {
      logic [31:0] write_data;
      logic        valid;
      logic        wen;
      logic        byte_not_word;
      logic        yumi;
   } mem_in_s;

   typedef struct packed {
      logic [31:0] read_data;
      logic        valid;
      logic        yumi;
   } mem_out_s;
endpackage

// state  | meaning
// S_IDLE | waiting for a request; yumi follows mem_i.valid combinationally
// S_BUSY | request accepted, latency counter running down
// S_RESP | response valid and held until the core consumes it
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH_P = 12,
   parameter int LATENCY_P    = 2
) (
   input  logic                    clk,
   input  logic                    n_reset,
   input  logic [ADDR_WIDTH_P-1:0] addr_i,
   input  mem_in_s                 mem_i,
   output mem_out_s                mem_o
);

   localparam int WORDS_LP = 2 ** (ADDR_WIDTH_P - 2);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [3:0]              r_cnt;
   logic [3:0]              w_cnt_nxt;
   logic                    w_yumi;
   logic                    w_load_rd;
   logic                    w_accept;

   logic [ADDR_WIDTH_P-1:0] r_addr;
   logic                    r_wen;
   logic                    r_bnw;
   logic [31:0]             r_rdata;

   logic [31:0]             r_mem [WORDS_LP];

   logic [ADDR_WIDTH_P-3:0] w_rd_idx;
   logic [1:0]              w_rd_lane;
   logic                    w_rd_wen;
   logic                    w_rd_bnw;
   logic [31:0]             w_rd_word;
   logic [31:0]             w_rd_data;

   assign w_accept = (r_state == S_IDLE) && mem_i.valid && n_reset;

   // Next-state, counter and handshake decode.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_yumi      = 1'b0;
      w_load_rd   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_yumi = mem_i.valid && n_reset;
            if (w_yumi) begin
               w_cnt_nxt = 4'(LATENCY_P - 1);
               if (LATENCY_P == 1) begin
                  w_state_nxt = S_RESP;
                  w_load_rd   = 1'b1;
               end else begin
                  w_state_nxt = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_state_nxt = S_RESP;
               w_load_rd   = 1'b1;
            end
         end
         S_RESP: begin
            if (mem_i.yumi) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // With a one-cycle latency the response is captured in the accept cycle,
   // so the read path looks at the live request instead of the latched one.
   always_comb begin
      w_rd_idx  = r_addr[ADDR_WIDTH_P-1:2];
      w_rd_lane = r_addr[1:0];
      w_rd_wen  = r_wen;
      w_rd_bnw  = r_bnw;
      if (r_state == S_IDLE) begin
         w_rd_idx  = addr_i[ADDR_WIDTH_P-1:2];
         w_rd_lane = addr_i[1:0];
         w_rd_wen  = mem_i.wen;
         w_rd_bnw  = mem_i.byte_not_word;
      end
      w_rd_word = r_mem[w_rd_idx];
      w_rd_data = 32'h0;
      if (!w_rd_wen) begin
         if (w_rd_bnw) w_rd_data = {24'h0, w_rd_word[{w_rd_lane, 3'b000} +: 8]};
         else          w_rd_data = w_rd_word;
      end
   end

   // State, counter and response register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_rdata <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_load_rd) r_rdata <= w_rd_data;
      end
   end

   // Latch the request attributes needed later to form the response.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr <= addr_i;
         r_wen  <= mem_i.wen;
         r_bnw  <= mem_i.byte_not_word;
      end
   end

   // RAM write at the acceptance edge; byte writes touch only one lane.
   always_ff @(posedge clk) begin
      if (w_accept && mem_i.wen) begin
         for (int k = 0; k < 4; k++) begin
            if (!mem_i.byte_not_word)
               r_mem[addr_i[ADDR_WIDTH_P-1:2]][8*k +: 8] <= mem_i.write_data[8*k +: 8];
            else if (addr_i[1:0] == 2'(k))
               r_mem[addr_i[ADDR_WIDTH_P-1:2]][8*k +: 8] <= mem_i.write_data[7:0];
         end
      end
   end

   assign mem_o = '{read_data: r_rdata, valid: (r_state == S_RESP), yumi: w_yumi};

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 2, 1, 15) checked
// against a word-array memory model and the latency rule.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   logic        clk;
   logic        n_reset;
   logic [11:0] ad [3];
   mem_in_s     mi [3];
   mem_out_s    mo [3];

   int n_cmp = 0;
   int n_err = 0;
   int lat_of [3] = '{2, 1, 15};

   logic [31:0] ref_mem [3][16];

   logic [31:0] t_rd;
   int          t_lat;
   int          t_acc;
   bit          t_stable;
   bit          t_dropped;

   dmem_responder #(.ADDR_WIDTH_P(12), .LATENCY_P(2)) u_dut_l2 (
      .clk(clk), .n_reset(n_reset), .addr_i(ad[0]), .mem_i(mi[0]), .mem_o(mo[0]));
   dmem_responder #(.ADDR_WIDTH_P(12), .LATENCY_P(1)) u_dut_l1 (
      .clk(clk), .n_reset(n_reset), .addr_i(ad[1]), .mem_i(mi[1]), .mem_o(mo[1]));
   dmem_responder #(.ADDR_WIDTH_P(12), .LATENCY_P(15)) u_dut_l15 (
      .clk(clk), .n_reset(n_reset), .addr_i(ad[2]), .mem_i(mi[2]), .mem_o(mo[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_read(int d, logic [11:0] a, bit bnw);
      logic [31:0] w;
      w = ref_mem[d][a[5:2]];
      if (bnw) return (w >> (8 * a[1:0])) & 32'hFF;
      return w;
   endfunction

   function automatic void ref_write(int d, logic [11:0] a, bit bnw, logic [31:0] wd);
      logic [31:0] mask;
      if (!bnw) begin
         ref_mem[d][a[5:2]] = wd;
      end else begin
         mask = 32'hFF << (8 * a[1:0]);
         ref_mem[d][a[5:2]] = (ref_mem[d][a[5:2]] & ~mask) | ((wd & 32'hFF) << (8 * a[1:0]));
      end
   endfunction

   // Runs one complete request/response on instance d and records what it saw.
   task automatic txn(input int d, input bit wen, input bit bnw, input logic [11:0] a,
                      input logic [31:0] wd, input int hold);
      t_rd = 32'hx; t_lat = 0; t_acc = 0; t_stable = 1; t_dropped = 0;
      @(negedge clk);
      mi[d].write_data = wd; mi[d].wen = wen; mi[d].byte_not_word = bnw;
      mi[d].valid = 1'b1; mi[d].yumi = 1'b0; ad[d] = a;
      #1;
      while (mo[d].yumi !== 1'b1 && t_acc < 20) begin
         @(negedge clk); #1; t_acc++;
      end
      @(negedge clk);
      mi[d].valid = 1'b0; ad[d] = 12'($urandom); mi[d].write_data = $urandom;
      mi[d].wen = 1'($urandom); mi[d].byte_not_word = 1'($urandom);
      #1; t_lat = 1;
      while (mo[d].valid !== 1'b1 && t_lat < 40) begin
         @(negedge clk); #1; t_lat++;
      end
      if (mo[d].valid !== 1'b1) return;
      t_rd = mo[d].read_data;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk); #1;
         if (mo[d].valid !== 1'b1 || mo[d].read_data !== t_rd) t_stable = 0;
      end
      mi[d].yumi = 1'b1;
      @(negedge clk);
      mi[d].yumi = 1'b0;
      #1;
      t_dropped = (mo[d].valid === 1'b0);
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         mi[d] = '{write_data: 32'h0, valid: 1'b1, wen: 1'b0, byte_not_word: 1'b0, yumi: 1'b0};
         ad[d] = 12'h0;
      end
      repeat (3) @(negedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (mo[d].yumi !== 1'b0) begin
            n_err++; $display("FAIL reset_yumi d=%0d got=%b exp=0", d, mo[d].yumi);
         end
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) mi[d].valid = 1'b0;
      n_reset = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (mo[d] !== 34'h0) begin
            n_err++; $display("FAIL reset_out d=%0d got=%h exp=0", d, mo[d]);
         end
      end
   endtask

   task automatic test_init();
      logic [31:0] v;
      for (int d = 0; d < 3; d++) begin
         for (int w = 0; w < 16; w++) begin
            v = $urandom;
            txn(d, 1'b1, 1'b0, 12'(w * 4 + int'($urandom_range(0, 3))), v, 0);
            ref_write(d, 12'(w * 4), 1'b0, v);
            n_cmp++;
            if (t_lat !== lat_of[d] || t_rd !== 32'h0) begin
               n_err++;
               $display("FAIL init_write d=%0d w=%0d got lat=%0d data=%h exp lat=%0d data=0",
                        d, w, t_lat, t_rd, lat_of[d]);
            end
         end
      end
   endtask

   task automatic test_word_rw();
      txn(0, 1'b1, 1'b0, 12'h010, 32'hDEADBEEF, 0);
      ref_write(0, 12'h010, 1'b0, 32'hDEADBEEF);
      n_cmp++;
      if (t_acc !== 0 || t_lat !== 2 || t_rd !== 32'h0) begin
         n_err++; $display("FAIL word_write got acc=%0d lat=%0d data=%h exp 0/2/0", t_acc, t_lat, t_rd);
      end
      txn(0, 1'b0, 1'b0, 12'h010, 32'h0, 0);
      n_cmp++;
      if (t_lat !== 2 || t_rd !== 32'hDEADBEEF || !t_dropped) begin
         n_err++;
         $display("FAIL word_read got lat=%0d data=%h dropped=%b exp 2/deadbeef/1", t_lat, t_rd, t_dropped);
      end
   endtask

   task automatic test_byte_merge();
      txn(0, 1'b1, 1'b0, 12'h020, 32'h11223344, 0);
      ref_write(0, 12'h020, 1'b0, 32'h11223344);
      txn(0, 1'b1, 1'b1, 12'h022, 32'h5566_77AA, 0);
      ref_write(0, 12'h022, 1'b1, 32'h556677AA);
      txn(0, 1'b0, 1'b0, 12'h020, 32'h0, 0);
      n_cmp++;
      if (t_rd !== 32'h11AA3344) begin
         n_err++; $display("FAIL byte_merge_word got=%h exp=11aa3344", t_rd);
      end
      txn(0, 1'b0, 1'b1, 12'h023, 32'h0, 0);
      n_cmp++;
      if (t_rd !== 32'h00000011) begin
         n_err++; $display("FAIL byte_merge_lbu got=%h exp=00000011", t_rd);
      end
   endtask

   task automatic test_hold();
      txn(0, 1'b0, 1'b0, 12'h010, 32'h0, 5);
      n_cmp++;
      if (t_rd !== 32'hDEADBEEF || !t_stable || !t_dropped) begin
         n_err++;
         $display("FAIL hold got data=%h stable=%b dropped=%b exp deadbeef/1/1", t_rd, t_stable, t_dropped);
      end
   endtask

   task automatic test_overlap();
      int c;
      bit early;
      @(negedge clk);
      mi[0] = '{write_data: 32'h0, valid: 1'b1, wen: 1'b0, byte_not_word: 1'b0, yumi: 1'b0};
      ad[0] = 12'h010;
      #1;
      n_cmp++;
      if (mo[0].yumi !== 1'b1) begin
         n_err++; $display("FAIL overlap_first_accept got=%b exp=1", mo[0].yumi);
      end
      early = 0; c = 0;
      do begin
         @(negedge clk); #1; c++;
         if (mo[0].yumi !== 1'b0) early = 1;
      end while (mo[0].valid !== 1'b1 && c < 40);
      ad[0] = 12'h020;
      mi[0].yumi = 1'b1;
      #1;
      if (mo[0].yumi !== 1'b0) early = 1;
      n_cmp++;
      if (mo[0].read_data !== ref_read(0, 12'h010, 1'b0) || c !== 2) begin
         n_err++; $display("FAIL overlap_first_resp got data=%h lat=%0d exp %h/2",
                           mo[0].read_data, c, ref_read(0, 12'h010, 1'b0));
      end
      n_cmp++;
      if (early) begin
         n_err++; $display("FAIL overlap_early_yumi got=1 exp=0");
      end
      @(negedge clk);
      mi[0].yumi = 1'b0;
      #1;
      n_cmp++;
      if (mo[0].yumi !== 1'b1 || mo[0].valid !== 1'b0) begin
         n_err++; $display("FAIL overlap_second_accept got yumi=%b valid=%b exp 1/0", mo[0].yumi, mo[0].valid);
      end
      @(negedge clk);
      mi[0].valid = 1'b0;
      #1; c = 1;
      while (mo[0].valid !== 1'b1 && c < 40) begin
         @(negedge clk); #1; c++;
      end
      n_cmp++;
      if (c !== 2 || mo[0].read_data !== ref_read(0, 12'h020, 1'b0)) begin
         n_err++; $display("FAIL overlap_second_resp got lat=%0d data=%h exp 2/%h",
                           c, mo[0].read_data, ref_read(0, 12'h020, 1'b0));
      end
      mi[0].yumi = 1'b1;
      @(negedge clk);
      mi[0].yumi = 1'b0;
   endtask

   task automatic test_reset_midop();
      bit seen;
      @(negedge clk);
      mi[0] = '{write_data: 32'h0, valid: 1'b1, wen: 1'b0, byte_not_word: 1'b0, yumi: 1'b0};
      ad[0] = 12'h020;
      #1;
      n_cmp++;
      if (mo[0].yumi !== 1'b1) begin
         n_err++; $display("FAIL midop_accept got=%b exp=1", mo[0].yumi);
      end
      @(negedge clk);
      mi[0].valid = 1'b0;
      n_reset = 1'b0;
      @(negedge clk);
      n_reset = 1'b1;
      seen = 0;
      repeat (6) begin
         #1;
         if (mo[0].valid !== 1'b0) seen = 1;
         @(negedge clk);
      end
      n_cmp++;
      if (seen) begin
         n_err++; $display("FAIL midop_valid got=1 exp=0");
      end
      txn(0, 1'b0, 1'b0, 12'h020, 32'h0, 0);
      n_cmp++;
      if (t_acc !== 0 || t_lat !== 2 || t_rd !== ref_read(0, 12'h020, 1'b0)) begin
         n_err++; $display("FAIL midop_next got acc=%0d lat=%0d data=%h exp 0/2/%h",
                           t_acc, t_lat, t_rd, ref_read(0, 12'h020, 1'b0));
      end
   endtask

   task automatic test_latency_sweep();
      logic [11:0] a;
      for (int d = 1; d < 3; d++) begin
         a = 12'($urandom_range(0, 63));
         txn(d, 1'b0, 1'b0, a, 32'h0, 0);
         n_cmp++;
         if (t_lat !== lat_of[d] || t_rd !== ref_read(d, a, 1'b0)) begin
            n_err++; $display("FAIL sweep_read d=%0d got lat=%0d data=%h exp %0d/%h",
                              d, t_lat, t_rd, lat_of[d], ref_read(d, a, 1'b0));
         end
         a = 12'($urandom_range(0, 63));
         txn(d, 1'b0, 1'b1, a, 32'h0, 1);
         n_cmp++;
         if (t_lat !== lat_of[d] || t_rd !== ref_read(d, a, 1'b1) || !t_stable) begin
            n_err++; $display("FAIL sweep_lbu d=%0d got lat=%0d data=%h exp %0d/%h",
                              d, t_lat, t_rd, lat_of[d], ref_read(d, a, 1'b1));
         end
      end
   endtask

   task automatic test_random();
      bit          wen, bnw;
      logic [11:0] a;
      logic [31:0] wd, exp_rd;
      int          hold;
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 25; i++) begin
            wen = 1'($urandom); bnw = 1'($urandom);
            a = 12'($urandom_range(0, 63)); wd = $urandom; hold = int'($urandom_range(0, 2));
            exp_rd = wen ? 32'h0 : ref_read(d, a, bnw);
            txn(d, wen, bnw, a, wd, hold);
            if (wen) ref_write(d, a, bnw, wd);
            n_cmp++;
            if (t_acc !== 0 || t_lat !== lat_of[d] || t_rd !== exp_rd || !t_stable || !t_dropped) begin
               n_err++;
               $display("FAIL random d=%0d i=%0d wen=%b bnw=%b a=%h got acc=%0d lat=%0d data=%h st=%b dr=%b exp 0/%0d/%h/1/1",
                        d, i, wen, bnw, a, t_acc, t_lat, t_rd, t_stable, t_dropped, lat_of[d], exp_rd);
            end
         end
      end
   endtask

   initial begin
      n_reset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         mi[d] = '0;
         ad[d] = 12'h0;
      end
      test_reset();
      test_init();
      test_word_rw();
      test_byte_merge();
      test_hold();
      test_overlap();
      test_reset_midop();
      test_latency_sweep();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
